// File: rtl/sifh_sram_sched_if.sv
// Bundle of the scheduler's requester inputs and SRAM/control outputs.
// slave is the scheduler's view; master is the environment's view
// (builder, peak finder, filter and SRAM macro, or a testbench).
interface sifh_sram_sched_if #(
  parameter int RAM_ADDR = 10,
  parameter int PEAK_MAX = 16
);
  logic                start;
  logic [RAM_ADDR-1:0] hb_waddr;
  logic [RAM_ADDR-1:0] hb_raddr;
  logic                hb_wen;
  logic                hb_ren;
  logic [PEAK_MAX-1:0] hb_wdata;
  logic                hb_done;
  logic [RAM_ADDR-1:0] pf_raddr;
  logic                pf_ren;
  logic                pf_done;
  logic                filt_done;

  logic [RAM_ADDR-1:0] waddr;
  logic [RAM_ADDR-1:0] raddr;
  logic                wEnable;
  logic                rEnable;
  logic                writeFlag;
  logic                readFlag;
  logic [PEAK_MAX-1:0] newCounts;
  logic                wrEn;
  logic                pf_go;
  logic                filt_go;
  logic                pass;
  logic [2:0]          phase;
  logic                frame_done;

  modport slave (
    input  start, hb_waddr, hb_raddr, hb_wen, hb_ren, hb_wdata, hb_done,
           pf_raddr, pf_ren, pf_done, filt_done,
    output waddr, raddr, wEnable, rEnable, writeFlag, readFlag, newCounts,
           wrEn, pf_go, filt_go, pass, phase, frame_done
  );

  modport master (
    output start, hb_waddr, hb_raddr, hb_wen, hb_ren, hb_wdata, hb_done,
           pf_raddr, pf_ren, pf_done, filt_done,
    input  waddr, raddr, wEnable, rEnable, writeFlag, readFlag, newCounts,
           wrEn, pf_go, filt_go, pass, phase, frame_done
  );
endinterface

// File: rtl/sifh_sram_sched.sv
// SiFH histogram SRAM frame scheduler.
// Runs clear -> build -> drain -> peak -> filter, then a second
// clear -> build -> drain -> peak pass, and owns the SRAM ports by phase.
// Every output is a register loaded from the next-state view, so the
// registered phase always matches the cycle's SRAM activity.
module sifh_sram_sched #(
  parameter int          RAM_ADDR     = 10,
  parameter int          PEAK_MAX     = 16,
  parameter int          DEPTH        = 1024,
  parameter logic [23:0] BUILD_CYCLES = 24'd1000000,
  parameter int          DRAIN_CYCLES = 3
) (
  input logic               clk,
  input logic               res,
  sifh_sram_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_BUILD  = 3'd2,
    S_DRAIN  = 3'd3,
    S_PEAK   = 3'd4,
    S_FILTER = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [RAM_ADDR-1:0] CLR_LAST   = RAM_ADDR'(DEPTH - 1);
  localparam logic [23:0]         EXP_LAST   = BUILD_CYCLES - 24'd1;
  localparam logic [7:0]          DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [RAM_ADDR-1:0] r_clrCnt;
  logic [RAM_ADDR-1:0] w_clrNext;
  logic [23:0]         r_expCnt;
  logic [7:0]          r_drainCnt;
  logic                r_pass;

  logic [RAM_ADDR-1:0] w_waddr,     r_waddr;
  logic [RAM_ADDR-1:0] w_raddr,     r_raddr;
  logic                w_wEnable,   r_wEnable;
  logic                w_rEnable,   r_rEnable;
  logic                w_writeFlag, r_writeFlag;
  logic                w_readFlag,  r_readFlag;
  logic [PEAK_MAX-1:0] w_newCounts, r_newCounts;
  logic                w_wrEn,      r_wrEn;
  logic                w_pfGo,      r_pfGo;
  logic                w_filtGo,    r_filtGo;
  logic                w_frameDone, r_frameDone;
  logic [2:0]          w_phase,     r_phase;

  // Clear address for the coming cycle: restarts at 0 on every entry to CLEAR
  assign w_clrNext = (r_state == S_CLEAR && w_nextState == S_CLEAR) ?
                     r_clrCnt + 1'b1 : '0;

  // Phase sequencing; done/start strobes are only looked at in their own phase
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_nextState = S_CLEAR;
      S_CLEAR:  if (r_clrCnt == CLR_LAST) w_nextState = S_BUILD;
      S_BUILD:  if (bus.hb_done || r_expCnt == EXP_LAST) w_nextState = S_DRAIN;
      S_DRAIN:  if (r_drainCnt == DRAIN_LAST) w_nextState = S_PEAK;
      S_PEAK:   if (bus.pf_done) w_nextState = r_pass ? S_DONE : S_FILTER;
      S_FILTER: if (bus.filt_done) w_nextState = S_CLEAR;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // State, phase counters and pass bit; the exposure and drain counters sit at 0 outside their phase
  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= S_IDLE;
      r_clrCnt   <= '0;
      r_expCnt   <= '0;
      r_drainCnt <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_clrCnt   <= w_clrNext;
      r_expCnt   <= (r_state == S_BUILD) ? r_expCnt + 24'd1 : '0;
      r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + 8'd1 : '0;
      if (r_state == S_FILTER && w_nextState == S_CLEAR) begin
        r_pass <= 1'b1;
      end else if (r_state == S_IDLE || r_state == S_DONE) begin
        r_pass <= 1'b0;
      end
    end
  end

  // Port ownership for the coming cycle; a requester is forwarded only while it owns the phase now and next
  always_comb begin
    w_waddr     = '0;
    w_raddr     = '0;
    w_wEnable   = 1'b0;
    w_rEnable   = 1'b0;
    w_writeFlag = 1'b0;
    w_readFlag  = 1'b0;
    w_newCounts = '0;
    w_phase     = w_nextState;
    w_wrEn      = (w_nextState == S_BUILD);
    w_pfGo      = (r_state == S_DRAIN && w_nextState == S_PEAK);
    w_filtGo    = (r_state == S_PEAK && w_nextState == S_FILTER);
    w_frameDone = (w_nextState == S_DONE);
    if (w_nextState == S_CLEAR) begin
      w_waddr     = w_clrNext;
      w_wEnable   = 1'b1;
      w_writeFlag = 1'b1;
    end else if ((r_state inside {S_BUILD, S_DRAIN}) &&
                 (w_nextState inside {S_BUILD, S_DRAIN})) begin
      w_waddr     = bus.hb_waddr;
      w_raddr     = bus.hb_raddr;
      w_wEnable   = bus.hb_wen;
      w_rEnable   = bus.hb_ren;
      w_writeFlag = bus.hb_wen;
      w_readFlag  = bus.hb_ren;
      w_newCounts = bus.hb_wdata;
    end else if (r_state == S_PEAK && w_nextState == S_PEAK) begin
      w_raddr     = bus.pf_raddr;
      w_rEnable   = bus.pf_ren;
      w_readFlag  = bus.pf_ren;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (res) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_wEnable   <= 1'b0;
      r_rEnable   <= 1'b0;
      r_writeFlag <= 1'b0;
      r_readFlag  <= 1'b0;
      r_newCounts <= '0;
      r_wrEn      <= 1'b0;
      r_pfGo      <= 1'b0;
      r_filtGo    <= 1'b0;
      r_frameDone <= 1'b0;
      r_phase     <= 3'd0;
    end else begin
      r_waddr     <= w_waddr;
      r_raddr     <= w_raddr;
      r_wEnable   <= w_wEnable;
      r_rEnable   <= w_rEnable;
      r_writeFlag <= w_writeFlag;
      r_readFlag  <= w_readFlag;
      r_newCounts <= w_newCounts;
      r_wrEn      <= w_wrEn;
      r_pfGo      <= w_pfGo;
      r_filtGo    <= w_filtGo;
      r_frameDone <= w_frameDone;
      r_phase     <= w_phase;
    end
  end

  assign bus.waddr      = r_waddr;
  assign bus.raddr      = r_raddr;
  assign bus.wEnable    = r_wEnable;
  assign bus.rEnable    = r_rEnable;
  assign bus.writeFlag  = r_writeFlag;
  assign bus.readFlag   = r_readFlag;
  assign bus.newCounts  = r_newCounts;
  assign bus.wrEn       = r_wrEn;
  assign bus.pf_go      = r_pfGo;
  assign bus.filt_go    = r_filtGo;
  assign bus.pass       = r_pass;
  assign bus.phase      = r_phase;
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_sifh_sram_sched.sv
// Directed testbench for sifh_sram_sched (DEPTH=16, BUILD_CYCLES=100, DRAIN_CYCLES=3).
module tb_sifh_sram_sched;
  localparam int          RA  = 10;
  localparam int          PM  = 16;
  localparam int          DEP = 16;
  localparam logic [23:0] BC  = 24'd100;
  localparam int          DC  = 3;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   total = 0;
  int   bad = 0;

  int         frameDonePulses = 0;
  logic [2:0] lastPhase = 3'd0;
  logic [2:0] phaseLog[$];
  logic       logOn = 1'b0;

  sifh_sram_sched_if #(.RAM_ADDR(RA), .PEAK_MAX(PM)) bus();

  sifh_sram_sched #(
    .RAM_ADDR(RA), .PEAK_MAX(PM), .DEPTH(DEP),
    .BUILD_CYCLES(BC), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Record phase changes and frame_done pulses during the full frame
  always @(negedge clk) begin
    if (logOn) begin
      if (bus.frame_done === 1'b1) frameDonePulses++;
      if (bus.phase !== lastPhase) begin
        phaseLog.push_back(bus.phase);
        lastPhase = bus.phase;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.start = 0; bus.hb_waddr = '0; bus.hb_raddr = '0; bus.hb_wen = 0;
    bus.hb_ren = 0; bus.hb_wdata = '0; bus.hb_done = 0; bus.pf_raddr = '0;
    bus.pf_ren = 0; bus.pf_done = 0; bus.filt_done = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    res = 1; tick(); tick(); res = 0;
    total++; if ({bus.phase, bus.wrEn, bus.writeFlag, bus.readFlag, bus.pass, bus.frame_done} !== 8'b000_00000) begin
      bad++; $display("FAIL reset_ctrl: got phase=%0d wrEn=%b wf=%b rf=%b pass=%b fd=%b want all 0", bus.phase, bus.wrEn, bus.writeFlag, bus.readFlag, bus.pass, bus.frame_done); end
    total++; if (bus.waddr !== 10'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", bus.waddr); end
  endtask

  task automatic test_clear();
    logOn = 1;
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < DEP; i++) begin
      total++;
      if ({bus.phase, bus.waddr, bus.wEnable, bus.writeFlag, bus.newCounts, bus.readFlag, bus.rEnable} !==
          {3'd1, 10'(i), 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
        bad++; $display("FAIL clear_cycle%0d: got phase=%0d waddr=%0d we=%b wf=%b nc=%0h rf=%b want phase=1 waddr=%0d we=1 wf=1 nc=0 rf=0",
                        i, bus.phase, bus.waddr, bus.wEnable, bus.writeFlag, bus.newCounts, bus.readFlag, i);
      end
      tick();
    end
    total++; if ({bus.phase, bus.wrEn} !== {3'd2, 1'b1}) begin
      bad++; $display("FAIL clear_to_build: got phase=%0d wrEn=%b want 2/1", bus.phase, bus.wrEn); end
  endtask

  task automatic test_build_timeout();
    int n = 0;
    while (bus.wrEn === 1'b1 && n < 200) begin n++; tick(); end
    total++; if (n !== 100) begin bad++; $display("FAIL timeout_wrEn_len: got %0d want 100", n); end
    for (int k = 0; k < DC; k++) begin
      total++; if ({bus.phase, bus.wrEn, bus.pf_go} !== {3'd3, 1'b0, 1'b0}) begin
        bad++; $display("FAIL drain%0d: got phase=%0d wrEn=%b pf_go=%b want 3/0/0", k, bus.phase, bus.wrEn, bus.pf_go); end
      tick();
    end
    total++; if ({bus.phase, bus.pf_go} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL pf_go_pulse: got phase=%0d pf_go=%b want 4/1", bus.phase, bus.pf_go); end
  endtask

  task automatic test_peak_gating();
    bus.hb_waddr = 10'd7; bus.hb_wen = 1; bus.hb_wdata = 16'h0005; bus.hb_raddr = 10'd4;
    bus.hb_ren = 1; bus.pf_raddr = 10'd3; bus.pf_ren = 1; bus.hb_done = 1;
    tick(); clearInputs();
    total++; if ({bus.writeFlag, bus.wEnable, bus.newCounts} !== {1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL peak_porta_idle: got wf=%b we=%b nc=%0h want 0/0/0", bus.writeFlag, bus.wEnable, bus.newCounts); end
    total++; if ({bus.raddr, bus.readFlag, bus.rEnable} !== {10'd3, 1'b1, 1'b1}) begin
      bad++; $display("FAIL peak_portb: got raddr=%0d rf=%b re=%b want 3/1/1", bus.raddr, bus.readFlag, bus.rEnable); end
    total++; if ({bus.phase, bus.pf_go} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL peak_hold: got phase=%0d pf_go=%b want 4/0", bus.phase, bus.pf_go); end
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    total++; if ({bus.phase, bus.filt_go, bus.pass, bus.readFlag} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL to_filter: got phase=%0d filt_go=%b pass=%b rf=%b want 5/1/0/0", bus.phase, bus.filt_go, bus.pass, bus.readFlag); end
    bus.start = 1; bus.pf_done = 1; bus.hb_done = 1; tick(); clearInputs();
    total++; if ({bus.phase, bus.filt_go} !== {3'd5, 1'b0}) begin
      bad++; $display("FAIL filter_ignore: got phase=%0d filt_go=%b want 5/0", bus.phase, bus.filt_go); end
    bus.filt_done = 1; tick(); bus.filt_done = 0;
    total++; if ({bus.phase, bus.pass, bus.waddr, bus.writeFlag} !== {3'd1, 1'b1, 10'd0, 1'b1}) begin
      bad++; $display("FAIL second_clear_entry: got phase=%0d pass=%b waddr=%0d wf=%b want 1/1/0/1", bus.phase, bus.pass, bus.waddr, bus.writeFlag); end
    for (int i = 0; i < DEP; i++) begin
      if (bus.phase !== 3'd1 || bus.waddr !== 10'(i)) begin
        total++; bad++; $display("FAIL second_clear%0d: got phase=%0d waddr=%0d want 1/%0d", i, bus.phase, bus.waddr, i);
      end
      tick();
    end
    total++; if (bus.phase !== 3'd2) begin bad++; $display("FAIL second_build: got phase=%0d want 2", bus.phase); end
  endtask

  task automatic test_build_early();
    int n = 0;
    int d = 0;
    while (bus.wrEn === 1'b1 && n < 200) begin
      if (n == 0) begin
        bus.hb_waddr = 10'd7; bus.hb_wen = 1; bus.hb_wdata = 16'h0005; bus.hb_raddr = 10'd2; bus.hb_ren = 1;
      end
      if (n == 1) begin
        total++;
        if ({bus.waddr, bus.wEnable, bus.writeFlag, bus.newCounts, bus.raddr, bus.readFlag, bus.rEnable} !==
            {10'd7, 1'b1, 1'b1, 16'h0005, 10'd2, 1'b1, 1'b1}) begin
          bad++; $display("FAIL build_passthru: got waddr=%0d we=%b wf=%b nc=%0h raddr=%0d rf=%b want 7/1/1/5/2/1",
                          bus.waddr, bus.wEnable, bus.writeFlag, bus.newCounts, bus.raddr, bus.readFlag);
        end
        clearInputs();
      end
      bus.hb_done = (n == 5);
      n++; tick();
    end
    bus.hb_done = 0;
    total++; if (n !== 6) begin bad++; $display("FAIL early_wrEn_len: got %0d want 6", n); end
    while (bus.phase === 3'd3 && d < 10) begin d++; tick(); end
    total++; if (d !== 3) begin bad++; $display("FAIL early_drain_len: got %0d want 3", d); end
    total++; if ({bus.phase, bus.pf_go} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL early_pf_go: got phase=%0d pf_go=%b want 4/1", bus.phase, bus.pf_go); end
  endtask

  task automatic test_frame_end();
    int expSeq[11] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 6, 0};
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    total++; if ({bus.phase, bus.frame_done, bus.filt_go, bus.pass} !== {3'd6, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL done_state: got phase=%0d fd=%b filt_go=%b pass=%b want 6/1/0/1", bus.phase, bus.frame_done, bus.filt_go, bus.pass); end
    tick();
    total++; if ({bus.phase, bus.frame_done, bus.pass} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL back_to_idle: got phase=%0d fd=%b pass=%b want 0/0/0", bus.phase, bus.frame_done, bus.pass); end
    tick(); logOn = 0;
    total++; if (frameDonePulses !== 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", frameDonePulses); end
    total++; if (phaseLog.size() !== 11) begin bad++; $display("FAIL phase_seq_len: got %0d want 11", phaseLog.size()); end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (i >= phaseLog.size() || phaseLog[i] !== 3'(expSeq[i])) begin
        bad++; $display("FAIL phase_seq%0d: got %0d want %0d", i, (i < phaseLog.size()) ? phaseLog[i] : 3'd7, expSeq[i]);
      end
    end
  endtask

  task automatic test_reset_build();
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < DEP; i++) tick();
    total++; if (bus.phase !== 3'd2) begin bad++; $display("FAIL rb_in_build: got phase=%0d want 2", bus.phase); end
    bus.hb_wen = 1; bus.hb_ren = 1; bus.hb_waddr = 10'd9;
    res = 1; tick(); tick(); res = 0;
    total++; if ({bus.phase, bus.wrEn, bus.writeFlag, bus.readFlag, bus.pass} !== 7'b000_0000) begin
      bad++; $display("FAIL rb_ctrl: got phase=%0d wrEn=%b wf=%b rf=%b pass=%b want all 0", bus.phase, bus.wrEn, bus.writeFlag, bus.readFlag, bus.pass); end
    total++; if (bus.waddr !== 10'd0) begin bad++; $display("FAIL rb_waddr: got %0d want 0", bus.waddr); end
    clearInputs(); tick();
    total++; if (bus.phase !== 3'd0) begin bad++; $display("FAIL rb_stay_idle: got phase=%0d want 0", bus.phase); end
  endtask

  task automatic test_abort_clear();
    int n = 0;
    bus.start = 1; tick(); bus.start = 0;
    while (bus.waddr !== 10'd9 && n < 40) begin n++; tick(); end
    total++; if ({bus.phase, bus.waddr} !== {3'd1, 10'd9}) begin
      bad++; $display("FAIL ac_reach9: got phase=%0d waddr=%0d want 1/9", bus.phase, bus.waddr); end
    res = 1; tick(); res = 0;
    total++; if ({bus.phase, bus.waddr, bus.writeFlag} !== {3'd0, 10'd0, 1'b0}) begin
      bad++; $display("FAIL ac_abort: got phase=%0d waddr=%0d wf=%b want 0/0/0", bus.phase, bus.waddr, bus.writeFlag); end
    bus.start = 1; tick(); bus.start = 0;
    total++; if ({bus.phase, bus.waddr, bus.writeFlag} !== {3'd1, 10'd0, 1'b1}) begin
      bad++; $display("FAIL ac_restart: got phase=%0d waddr=%0d wf=%b want 1/0/1", bus.phase, bus.waddr, bus.writeFlag); end
    tick();
    total++; if (bus.waddr !== 10'd1) begin bad++; $display("FAIL ac_next: got waddr=%0d want 1", bus.waddr); end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_clear();
    test_build_timeout();
    test_peak_gating();
    test_build_early();
    test_frame_end();
    test_reset_build();
    test_abort_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Runaway guard
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
